led_frame_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 35 +++
 rtl/led_drv_handshake.sv | 57 +++++
 rtl/led_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_led_frame_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED frame sequencer.
//   - NUM_COLS          : columns in the frame buffer
//   - *_DEF constants   : default pos/opcode bytes for the driver protocol
//   - seq_state_t       : frame sequencer states
//   - hs_state_t        : driver handshake states
//   - ctrl_byte()       : builds the display-control byte
package led_seq_pkg;

    localparam int         NUM_COLS      = 16;
    localparam logic [7:0] CTRL_POS_DEF  = 8'hFF;
    localparam logic [7:0] CTRL_BASE_DEF = 8'h88;
    localparam logic [7:0] ADDR_BASE_DEF = 8'hC0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_CTRL_WAIT,
        S_PAUSE,
        S_DATA,
        S_DATA_WAIT
    } seq_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT_HI,
        H_WAIT_LO
    } hs_state_t;

    function automatic logic [7:0] ctrl_byte(input logic [7:0] base,
                                             input logic       on,
                                             input logic [2:0] bright);
        return base | {4'b0000, on, bright};
    endfunction

endpackage

// File: rtl/led_drv_handshake.sv
// led_drv_handshake: issues one transfer to the writepixels driver and
// tracks its busy-high-then-low acknowledgement.
//   CLK, RST      : clock, synchronous active-high reset
//   i_req         : requester wants to send (i_pos, i_value)
//   i_drv_busy    : driver busy
//   o_drv_valid   : registered single-cycle request pulse
//   o_drv_pos/val : registered bytes, held until the next pulse
//   o_fire        : request accepted this cycle (pulse appears next cycle)
//   o_ack         : driver finished this transfer (busy fell after rising)
import led_seq_pkg::*;

module led_drv_handshake (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_req,
    input  logic [7:0] i_pos,
    input  logic [7:0] i_value,
    input  logic       i_drv_busy,
    output logic       o_drv_valid,
    output logic [7:0] o_drv_pos,
    output logic [7:0] o_drv_value,
    output logic       o_fire,
    output logic       o_ack
);

    hs_state_t r_state;
    logic      w_fire;

    assign w_fire = i_req && (r_state == H_IDLE) && !i_drv_busy;
    assign o_fire = w_fire;
    assign o_ack  = (r_state == H_WAIT_LO) && !i_drv_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= H_IDLE;
            o_drv_valid <= 1'b0;
            o_drv_pos   <= 8'h00;
            o_drv_value <= 8'h00;
        end else begin
            o_drv_valid <= 1'b0;
            case (r_state)
                H_IDLE: begin
                    if (w_fire) begin
                        o_drv_valid <= 1'b1;
                        o_drv_pos   <= i_pos;
                        o_drv_value <= i_value;
                        r_state     <= H_WAIT_HI;
                    end
                end
                H_WAIT_HI: if (i_drv_busy)  r_state <= H_WAIT_LO;
                H_WAIT_LO: if (!i_drv_busy) r_state <= H_IDLE;
                default:                    r_state <= H_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: owns the 16-column LED frame buffer and sends full
// frames to the writepixels driver: control command, settle pause, then
// 16 addressed column writes.
//   CLK, RST            : clock, synchronous active-high reset
//   i_wr_en/addr/data   : column buffer write (any state, no backpressure)
//   i_cfg_valid/bright/on : brightness/enable update, applied next frame
//   i_drv_busy          : driver busy
//   o_drv_valid/pos/value : driver transfer request
//   o_seq_busy          : sequencer not idle
//   o_frame_done        : pulse after the 16th column is acknowledged
// Optional macro LEDSEQ_PERIODIC_REFRESH_EN: resend the frame every
// CLK_HZ/REFRESH_HZ cycles even when nothing changed.
import led_seq_pkg::*;

module led_frame_sequencer #(
    parameter int         CLK_HZ       = 25_000_000,
    parameter int         REFRESH_HZ   = 10,
    parameter int         PAUSE_CYCLES = 25_000,
    parameter logic [7:0] CTRL_POS     = CTRL_POS_DEF,
    parameter logic [7:0] CTRL_BASE    = CTRL_BASE_DEF,
    parameter logic [7:0] ADDR_BASE    = ADDR_BASE_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_cfg_valid,
    input  logic [2:0] i_cfg_bright,
    input  logic       i_cfg_on,
    input  logic       i_drv_busy,
    output logic       o_drv_valid,
    output logic [7:0] o_drv_pos,
    output logic [7:0] o_drv_value,
    output logic       o_seq_busy,
    output logic       o_frame_done
);

    localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    seq_state_t r_state;
    logic [7:0] r_buf [NUM_COLS];
    logic [2:0] r_bright;
    logic       r_on;
    logic       r_dirty;
    logic [3:0] r_col;
    logic [PW-1:0] r_pause;

    logic       w_req, w_fire, w_ack, w_refresh, w_start, w_set_dirty;
    logic [7:0] w_pos, w_value;

`ifdef LEDSEQ_PERIODIC_REFRESH_EN
    localparam int RDIV = CLK_HZ / REFRESH_HZ;
    localparam int RW   = (RDIV > 1) ? $clog2(RDIV) : 1;

    logic [RW-1:0] r_ref_cnt;
    logic          r_ref_req;
    logic          w_tick;

    assign w_tick = (r_ref_cnt == RW'(RDIV - 1));

    // Ticks merge into one pending request; IDLE always consumes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ref_cnt <= '0;
            r_ref_req <= 1'b0;
        end else begin
            r_ref_cnt <= w_tick ? '0 : r_ref_cnt + 1'b1;
            if (w_tick)                r_ref_req <= 1'b1;
            else if (r_state == S_IDLE) r_ref_req <= 1'b0;
        end
    end
    assign w_refresh = r_ref_req;
`else
    assign w_refresh = 1'b0;
`endif

    assign w_set_dirty = i_wr_en | i_cfg_valid;
    assign w_start     = (r_state == S_IDLE) && (r_dirty || w_refresh);
    assign w_req       = (r_state == S_CTRL) || (r_state == S_DATA);
    assign w_pos       = (r_state == S_CTRL) ? CTRL_POS : ADDR_BASE + {4'd0, r_col};
    assign w_value     = (r_state == S_CTRL) ? ctrl_byte(CTRL_BASE, r_on, r_bright)
                                             : r_buf[r_col];
    assign o_seq_busy  = (r_state != S_IDLE);

    led_drv_handshake u_hs (
        .CLK         (CLK),
        .RST         (RST),
        .i_req       (w_req),
        .i_pos       (w_pos),
        .i_value     (w_value),
        .i_drv_busy  (i_drv_busy),
        .o_drv_valid (o_drv_valid),
        .o_drv_pos   (o_drv_pos),
        .o_drv_value (o_drv_value),
        .o_fire      (w_fire),
        .o_ack       (w_ack)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_bright     <= 3'd1;
            r_on         <= 1'b1;
            r_dirty      <= 1'b1;   // forces a blank frame out of reset
            r_col        <= 4'd0;
            r_pause      <= '0;
            o_frame_done <= 1'b0;
            for (int i = 0; i < NUM_COLS; i++) r_buf[i] <= 8'h00;
        end else begin
            o_frame_done <= 1'b0;
            if (i_wr_en) r_buf[i_wr_addr] <= i_wr_data;
            if (i_cfg_valid) begin
                r_bright <= i_cfg_bright;
                r_on     <= i_cfg_on;
            end
            // A new request in the consuming cycle keeps dirty set.
            if (w_start)          r_dirty <= w_set_dirty;
            else if (w_set_dirty) r_dirty <= 1'b1;

            case (r_state)
                S_IDLE:      if (w_start) r_state <= S_CTRL;
                S_CTRL:      if (w_fire)  r_state <= S_CTRL_WAIT;
                S_CTRL_WAIT: begin
                    if (w_ack) begin
                        r_pause <= '0;
                        r_state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (r_pause == PW'(PAUSE_CYCLES - 1)) begin
                        r_col   <= 4'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_pause <= r_pause + 1'b1;
                    end
                end
                S_DATA:      if (w_fire) r_state <= S_DATA_WAIT;
                S_DATA_WAIT: begin
                    if (w_ack) begin
                        if (r_col == 4'd15) begin
                            o_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_col   <= r_col + 1'b1;
                            r_state <= S_DATA;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer (default build, refresh macro off).
// The stimulus process plans random column/config writes around each frame,
// predicts the resulting driver transfers from the frame rules and queues
// them; a negedge monitor pops and compares on every valid / frame_done.
module tb_led_frame_sequencer;

    localparam int PAUSE = 40;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_wr_en = 1'b0;
    logic [3:0] i_wr_addr = 4'd0;
    logic [7:0] i_wr_data = 8'd0;
    logic       i_cfg_valid = 1'b0;
    logic [2:0] i_cfg_bright = 3'd0;
    logic       i_cfg_on = 1'b0;
    logic       i_drv_busy;
    logic       o_drv_valid;
    logic [7:0] o_drv_pos, o_drv_value;
    logic       o_seq_busy, o_frame_done;

    always #5 CLK = ~CLK;

    // Driver model: busy rises 2 cycles after a pulse, stays high 20 cycles.
    int   bcnt = 0;
    logic force_busy = 1'b0;
    always @(posedge CLK) begin
        if (o_drv_valid)   bcnt <= 22;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign i_drv_busy = force_busy | ((bcnt > 0) && (bcnt <= 20));

    led_frame_sequencer #(.CLK_HZ(1000), .REFRESH_HZ(10), .PAUSE_CYCLES(PAUSE)) dut (
        .CLK(CLK), .RST(RST),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_cfg_valid(i_cfg_valid), .i_cfg_bright(i_cfg_bright), .i_cfg_on(i_cfg_on),
        .i_drv_busy(i_drv_busy),
        .o_drv_valid(o_drv_valid), .o_drv_pos(o_drv_pos), .o_drv_value(o_drv_value),
        .o_seq_busy(o_seq_busy), .o_frame_done(o_frame_done)
    );

    typedef struct {
        bit         done;
        logic [7:0] pos;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mbuf [16];
    logic [2:0] mbr;
    logic       m_on;

    function automatic logic [7:0] ctrlb();
        return 8'h88 | {4'b0000, m_on, mbr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h00;
        mbr  = 3'd1;
        m_on = 1'b1;
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [7:0] f [16]);
        exp_t e;
        e.done = 1'b0; e.pos = 8'hFF; e.val = c;
        q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            e.pos = 8'hC0 + 8'(i);
            e.val = f[i];
            q.push_back(e);
        end
        e.done = 1'b1; e.pos = 8'h00; e.val = 8'h00;
        q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   ctrl_t = 0;
    int   gap;
    logic prev_v = 1'b0;
    exp_t me;

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (o_drv_valid) begin
                chk("no_back_to_back_valid", {31'd0, prev_v}, 32'd0);
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_pulse: got pos=%0h val=%0h, expected none", o_drv_pos, o_drv_value);
                end else begin
                    me = q.pop_front();
                    if (me.done) begin
                        n_cmp++; n_bad++;
                        $display("FAIL order: got pulse pos=%0h, expected frame_done", o_drv_pos);
                    end else begin
                        chk("drv_pos", {24'd0, o_drv_pos}, {24'd0, me.pos});
                        chk("drv_value", {24'd0, o_drv_value}, {24'd0, me.val});
                    end
                end
                if (o_drv_pos == 8'hFF) ctrl_t = cyc;
                if (o_drv_pos == 8'hC0) begin
                    // driver idle 22 cycles after the control pulse, then the pause
                    gap = cyc - ctrl_t;
                    n_cmp++;
                    if (gap < PAUSE + 22 || gap > PAUSE + 26) begin
                        n_bad++;
                        $display("FAIL pause_gap: got %0d cycles, expected %0d..%0d", gap, PAUSE + 22, PAUSE + 26);
                    end
                end
            end
            if (o_frame_done) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_frame_done: got 1, expected none");
                end else begin
                    me = q.pop_front();
                    chk("frame_done_order", {31'd0, me.done}, 32'd1);
                end
            end
        end
        prev_v = o_drv_valid;
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit we, input logic [3:0] a, input logic [7:0] d,
                        input bit cv, input logic [2:0] br, input logic on);
        i_wr_en = we; i_wr_addr = a; i_wr_data = d;
        i_cfg_valid = cv; i_cfg_bright = br; i_cfg_on = on;
        @(negedge CLK);
        i_wr_en = 1'b0; i_cfg_valid = 1'b0;
    endtask

    task automatic wait_pos(input logic [7:0] p, input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (o_drv_valid && o_drv_pos == p) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL timeout_%s: pulse pos=%0h never seen", name, p);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (!o_seq_busy && q.size() == 0) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL timeout_idle: seq_busy=%0b queue=%0d, expected idle/empty", o_seq_busy, q.size());
    endtask

    logic [3:0] wa [3][4];
    logic [7:0] wd [3][4];
    int         wn [3];
    bit         wc [3];
    logic [2:0] wbr [3];
    logic       won [3];
    logic [7:0] f1 [16];
    logic [7:0] c1;

    task automatic model_apply(input int w);
        if (wc[w]) begin mbr = wbr[w]; m_on = won[w]; end
        for (int i = 0; i < wn[w]; i++) mbuf[wa[w][i]] = wd[w][i];
    endtask

    task automatic drive_wave(input int w);
        int nc;
        nc = (wn[w] > 0) ? wn[w] : int'(wc[w]);
        for (int i = 0; i < nc; i++)
            step(i < wn[w], wa[w][i], wd[w][i], (i == 0) && wc[w], wbr[w], won[w]);
    endtask

    initial begin
        int vcnt;
        bit rst_round;
        model_reset();
        for (int i = 0; i < 16; i++) f1[i] = 8'h00;
        push_frame(8'h89, f1);               // blank frame after reset
        repeat (3) @(negedge CLK);
        chk("rst_valid", {31'd0, o_drv_valid}, 32'd0);
        chk("rst_pos", {24'd0, o_drv_pos}, 32'd0);
        chk("rst_value", {24'd0, o_drv_value}, 32'd0);
        chk("rst_seq_busy", {31'd0, o_seq_busy}, 32'd0);
        chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
        RST = 1'b0;

        for (int r = 0; r < 8; r++) begin
            wait_idle();
            rst_round = (r == 3);
            // wave 0: one write (plus maybe config) while idle;
            // wave 1: during CTRL_WAIT; wave 2: while col 10 is in flight
            wn[0] = 1;
            wn[1] = rst_round ? 0 : $urandom_range(0, 3);
            wn[2] = rst_round ? 0 : $urandom_range(1, 4);
            for (int w = 0; w < 3; w++) begin
                for (int i = 0; i < 4; i++) begin
                    wa[w][i] = 4'($urandom_range(0, 15));
                    wd[w][i] = 8'($urandom);
                end
                wc[w]  = (r == 0) ? (w == 0) : bit'($urandom_range(0, 1));
                wbr[w] = (r == 0) ? 3'd7 : 3'($urandom_range(0, 7));
                won[w] = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (rst_round && w > 0) wc[w] = 1'b0;
            end
            if (r == 0) begin wa[0][0] = 4'd3; wd[0][0] = 8'hA5; end
            wa[2][0] = 4'd0;
            if (r == 1) wd[2][0] = 8'h55;

            model_apply(0);
            c1 = ctrlb();
            model_apply(1);
            for (int i = 0; i < 16; i++) f1[i] = mbuf[i];
            for (int i = 0; i < wn[2]; i++)
                if (wa[2][i] > 4'd10) f1[wa[2][i]] = wd[2][i];
            model_apply(2);
            push_frame(c1, f1);
            if (!rst_round) push_frame(ctrlb(), mbuf);

            if (r == 4) force_busy = 1'b1;
            drive_wave(0);
            if (r == 4) begin
                vcnt = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge CLK);
                    if (o_drv_valid) vcnt++;
                end
                chk("busy_hold_no_valid", vcnt, 0);
                force_busy = 1'b0;
            end

            if (rst_round) begin
                wait_pos(8'hC7, "col7");
                repeat (3) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                chk("midrst_valid", {31'd0, o_drv_valid}, 32'd0);
                chk("midrst_seq_busy", {31'd0, o_seq_busy}, 32'd0);
                chk("midrst_frame_done", {31'd0, o_frame_done}, 32'd0);
                RST = 1'b0;
                q.delete();
                model_reset();
                push_frame(ctrlb(), mbuf);
            end else begin
                wait_pos(8'hFF, "ctrl");
                drive_wave(1);
                wait_pos(8'hCA, "col10");
                drive_wave(2);
            end
        end

        wait_idle();
        repeat (300) @(negedge CLK);          // no further frames while clean
        chk("queue_empty_at_end", q.size(), 0);
        chk("idle_at_end", {31'd0, o_seq_busy}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
